// File: rtl/decode_writeback_if.sv
// decode_writeback_if: fetch/execute/memory-facing bus of the Y86-64 SEQ decode/write-back stage
// master drives icode, rA, rB, valE, valM, Cnd, halt, dbg_sel and reads valA, valB, dbg_data
// slave is the register-file side
interface decode_writeback_if;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        Cnd;
  logic        halt;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [3:0]  dbg_sel;
  logic [63:0] dbg_data;
  modport master (output icode, rA, rB, valE, valM, Cnd, halt, dbg_sel, input valA, valB, dbg_data);
  modport slave  (input icode, rA, rB, valE, valM, Cnd, halt, dbg_sel, output valA, valB, dbg_data);
endinterface

// File: rtl/decode_writeback.sv
// decode_writeback: Y86-64 SEQ decode/write-back stage with the 15-entry architectural register file
// clock, reset (async, active-high): plain ports
// bus (slave): icode/rA/rB select sources and destinations, valE/valM/Cnd/halt drive write-back,
//   valA/valB feed execute, dbg_sel/dbg_data give a combinational debug read
module decode_writeback #(
  parameter logic [63:0] RSP_RESET = 64'h0
) (
  input logic          clock,
  input logic          reset,
  decode_writeback_if.slave bus
);
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;
  logic [63:0] r_regs [0:14];
  logic [3:0]  w_src_a, w_src_b, w_dst_e, w_dst_m;
  always_comb begin
    w_src_a = (bus.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? bus.rA :
              (bus.icode inside {4'h9, 4'hB}) ? RSP : RNONE;
    w_src_b = (bus.icode inside {4'h4, 4'h5, 4'h6, 4'hC}) ? bus.rB :
              (bus.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : RNONE;
    // cmovXX only commits when execute reports the condition true
    w_dst_e = (bus.icode inside {4'h3, 4'h6, 4'hC}) ? bus.rB :
              (bus.icode == 4'h2) ? (bus.Cnd ? bus.rB : RNONE) :
              (bus.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : RNONE;
    w_dst_m = (bus.icode inside {4'h5, 4'hB}) ? bus.rA : RNONE;
  end
  assign bus.valA     = (w_src_a == RNONE) ? '0 : r_regs[w_src_a];
  assign bus.valB     = (w_src_b == RNONE) ? '0 : r_regs[w_src_b];
  assign bus.dbg_data = (bus.dbg_sel == RNONE) ? '0 : r_regs[bus.dbg_sel];
  // M port is written last so it wins when dstE == dstM (popq %rsp)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) r_regs[i] <= (i == 4) ? RSP_RESET : '0;
    end else if (!bus.halt) begin
      if (w_dst_e != RNONE) r_regs[w_dst_e] <= bus.valE;
      if (w_dst_m != RNONE) r_regs[w_dst_m] <= bus.valM;
    end
  end
endmodule

// File: tb/tb_decode_writeback.sv
// tb_decode_writeback: directed and randomized checks of decode_writeback against a register-file model
module tb_decode_writeback;
  localparam logic [63:0] RSP_RST = 64'h200;
  logic clock = 0;
  logic reset = 1;
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] m [0:15];
  decode_writeback_if bus ();
  decode_writeback #(.RSP_RESET(RSP_RST)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;

  function automatic logic [3:0] f_src_a(input logic [3:0] ic, input logic [3:0] ra);
    case (ic)
      4'h2, 4'h4, 4'h6, 4'hA: return ra;
      4'h9, 4'hB:             return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction
  function automatic logic [3:0] f_src_b(input logic [3:0] ic, input logic [3:0] rb);
    case (ic)
      4'h4, 4'h5, 4'h6, 4'hC: return rb;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction
  function automatic logic [3:0] f_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
    case (ic)
      4'h3, 4'h6, 4'hC:       return rb;
      4'h2:                   return c ? rb : 4'hF;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction
  function automatic logic [3:0] f_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
  endfunction
  function automatic logic [63:0] m_rd(input logic [3:0] s);
    return (s == 4'hF) ? 64'h0 : m[s];
  endfunction

  task automatic m_reset;
    for (int i = 0; i < 16; i++) m[i] = (i == 4) ? RSP_RST : 64'h0;
  endtask
  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] ve, input logic [63:0] vm, input logic c, input logic h);
    bus.icode = ic; bus.rA = ra; bus.rB = rb; bus.valE = ve; bus.valM = vm; bus.Cnd = c; bus.halt = h;
  endtask
  task automatic tick;
    logic [3:0] de, dm;
    de = f_dst_e(bus.icode, bus.rB, bus.Cnd);
    dm = f_dst_m(bus.icode, bus.rA);
    if (!reset && !bus.halt) begin
      if (de != 4'hF) m[de] = bus.valE;
      if (dm != 4'hF) m[dm] = bus.valM;
    end
    @(posedge clock);
    #1;
  endtask
  task automatic chk_reg(input string nm, input logic [3:0] s, input logic [63:0] exp);
    bus.dbg_sel = s;
    #1;
    n_cmp++;
    if (bus.dbg_data !== exp) begin
      n_err++;
      $display("FAIL %s reg%0d got %h want %h", nm, s, bus.dbg_data, exp);
    end
  endtask

  task automatic test_reset;
    m_reset();
    drive(4'h1, 4'h0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    #2;
    for (int s = 0; s < 15; s++) begin
      bus.dbg_sel = 4'(s);
      #1;
      n_cmp++;
      if (bus.dbg_data !== ((s == 4) ? 64'h200 : 64'h0)) begin
        n_err++;
        $display("FAIL reset_dbg reg%0d got %h want %h", s, bus.dbg_data, (s == 4) ? 64'h200 : 64'h0);
      end
    end
    drive(4'hA, 4'h0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (bus.valB !== 64'h200) begin n_err++; $display("FAIL reset_pushq_valB got %h want %h", bus.valB, 64'h200); end
    drive(4'h1, 4'h0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  task automatic test_irmovq_opq;
    drive(4'h3, 4'hF, 4'h2, 64'h1234, 64'h0, 1'b0, 1'b0);
    tick();
    drive(4'h6, 4'h2, 4'h2, 64'h0, 64'h0, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (bus.valA !== 64'h1234) begin n_err++; $display("FAIL opq_valA got %h want %h", bus.valA, 64'h1234); end
    n_cmp++;
    if (bus.valB !== 64'h1234) begin n_err++; $display("FAIL opq_valB got %h want %h", bus.valB, 64'h1234); end
    tick();
  endtask

  task automatic test_cmov;
    drive(4'h2, 4'h1, 4'h3, 64'h55, 64'h0, 1'b0, 1'b0);
    tick();
    chk_reg("cmov_cnd0", 4'h3, 64'h0);
    drive(4'h2, 4'h1, 4'h3, 64'h55, 64'h0, 1'b1, 1'b0);
    tick();
    chk_reg("cmov_cnd1", 4'h3, 64'h55);
  endtask

  task automatic test_popq_rsp;
    drive(4'hB, 4'h4, 4'hF, 64'h208, 64'hABCD, 1'b0, 1'b0);
    tick();
    chk_reg("popq_rsp_m_wins", 4'h4, 64'hABCD);
  endtask

  task automatic test_halt;
    drive(4'h5, 4'h7, 4'h0, 64'h0, 64'hDEAD, 1'b0, 1'b1);
    tick();
    chk_reg("mrmovq_halt", 4'h7, 64'h0);
    drive(4'h5, 4'h7, 4'h0, 64'h0, 64'hDEAD, 1'b0, 1'b0);
    tick();
    chk_reg("mrmovq_run", 4'h7, 64'hDEAD);
  endtask

  task automatic test_async_reset;
    drive(4'h3, 4'hF, 4'h5, 64'h9, 64'h0, 1'b0, 1'b0);
    tick();
    drive(4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);
    chk_reg("pre_reset_reg5", 4'h5, 64'h9);
    #1;
    reset = 1;
    m_reset();
    chk_reg("async_reset_reg5", 4'h5, 64'h0);
    chk_reg("async_reset_reg4", 4'h4, 64'h200);
    drive(4'h9, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (bus.valA !== 64'h200) begin n_err++; $display("FAIL reset_ret_valA got %h want %h", bus.valA, 64'h200); end
    drive(4'h3, 4'hF, 4'h5, 64'h77, 64'h0, 1'b0, 1'b0);
    tick();
    chk_reg("reset_blocks_write", 4'h5, 64'h0);
    drive(4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);
    reset = 0;
    #1;
  endtask

  task automatic test_rnone;
    drive(4'h3, 4'hF, 4'hF, 64'hFFFF_0000_1111_2222, 64'h0, 1'b0, 1'b0);
    tick();
    chk_reg("rnone_dbg", 4'hF, 64'h0);
    for (int s = 0; s < 15; s++) chk_reg("rnone_no_write", 4'(s), m[s]);
  endtask

  task automatic test_random;
    logic [63:0] ve, vm;
    for (int k = 0; k < 300; k++) begin
      ve = {$urandom, $urandom};
      vm = {$urandom, $urandom};
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ve, vm, 1'($urandom), ($urandom_range(0, 7) == 0));
      bus.dbg_sel = 4'($urandom_range(0, 15));
      #1;
      n_cmp++;
      if (bus.valA !== m_rd(f_src_a(bus.icode, bus.rA))) begin
        n_err++;
        $display("FAIL rand_valA ic=%h rA=%h got %h want %h", bus.icode, bus.rA, bus.valA, m_rd(f_src_a(bus.icode, bus.rA)));
      end
      n_cmp++;
      if (bus.valB !== m_rd(f_src_b(bus.icode, bus.rB))) begin
        n_err++;
        $display("FAIL rand_valB ic=%h rB=%h got %h want %h", bus.icode, bus.rB, bus.valB, m_rd(f_src_b(bus.icode, bus.rB)));
      end
      n_cmp++;
      if (bus.dbg_data !== m_rd(bus.dbg_sel)) begin
        n_err++;
        $display("FAIL rand_dbg sel=%h got %h want %h", bus.dbg_sel, bus.dbg_data, m_rd(bus.dbg_sel));
      end
      tick();
    end
    for (int s = 0; s < 16; s++) chk_reg("rand_final", 4'(s), m_rd(4'(s)));
  endtask

  initial begin
    bus.dbg_sel = 4'h0;
    test_reset();
    test_irmovq_opq();
    test_cmov();
    test_popq_rsp();
    test_halt();
    test_async_reset();
    test_rnone();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
